// File: rtl/mem_dump_pkg.sv
// Shared definitions for the memory dump unit: FSM encoding and header byte.
// The HEADER state only exists when MEM_DUMP_HEADER_EN is defined.
package mem_dump_pkg;

  localparam logic [7:0] HEADER_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_READ   = 3'd1,
    ST_SEND   = 3'd2,
    ST_FINISH = 3'd3
`ifdef MEM_DUMP_HEADER_EN
    ,
    ST_HEADER = 3'd4
`endif
  } state_t;

endpackage

// File: rtl/mem_dump_if.sv
// Bus bundle between the dump unit, its data memory and the UART transmitter.
// The dump unit is the master; memory and transmitter sit on the slave side.
interface mem_dump_if #(
  parameter int addr_bus  = 11,
  parameter int data_size = 16
);
  logic                 Mem_Rd;
  logic [addr_bus-1:0]  Mem_Addr;
  logic [data_size-1:0] Mem_Data;
  logic [7:0]           Tx_Data;
  logic                 Tx_Valid;
  logic                 Tx_Ready;

  // Tx handshake: a byte moves on a rising Clk edge where Tx_Valid and
  // Tx_Ready are both 1; while Tx_Valid=1 and Tx_Ready=0 the master holds
  // Tx_Data and Tx_Valid unchanged. Tx_Ready may depend on nothing of ours.
  modport master (
    output Mem_Rd, Mem_Addr, Tx_Data, Tx_Valid,
    input  Mem_Data, Tx_Ready
  );

  modport slave (
    input  Mem_Rd, Mem_Addr, Tx_Data, Tx_Valid,
    output Mem_Data, Tx_Ready
  );
endinterface

// File: rtl/mem_dump_word_serializer.sv
// Splits a loaded memory word into bytes, most significant byte first,
// stepping the byte index on each accepted transfer.
module word_serializer #(
  parameter int  data_size = 16,
  localparam int nbytes    = data_size / 8,
  localparam int idx_w     = (nbytes > 1) ? $clog2(nbytes) : 1
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 load,
  input  logic [data_size-1:0] word,
  input  logic                 active,
  input  logic                 ready,
  output logic                 valid,
  output logic [7:0]           byte_data,
  output logic                 last_byte
);

  logic [data_size-1:0] word_q;
  logic [idx_w-1:0]     idx_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      word_q <= '0;
      idx_q  <= '0;
    end else if (load) begin
      word_q <= word;
      idx_q  <= '0;
    end else if (active && ready) begin
      idx_q <= last_byte ? '0 : idx_q + idx_w'(1);
    end
  end

  assign valid     = active;
  assign last_byte = (idx_q == idx_w'(nbytes - 1));

  // Index 0 selects the top byte of the word.
  always_comb begin
    byte_data = '0;
    for (int i = 0; i < nbytes; i++) begin
      if (idx_q == idx_w'(i)) byte_data = word_q[(nbytes-1-i)*8 +: 8];
    end
  end

endmodule

// File: rtl/mem_dump_unit.sv
// Reads data memory words 0..Last_Addr and streams them MSB-first to a UART.
// Define MEM_DUMP_HEADER_EN to prefix the dump with HEADER_BYTE.
module mem_dump_unit
  import mem_dump_pkg::*;
#(
  parameter int addr_bus  = 11,
  parameter int data_size = 16
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Start,
  input  logic [addr_bus-1:0] Last_Addr,
  mem_dump_if.master          bus,
  output logic                Busy,
  output logic                Done,
  output state_t              dbg_state
);

  state_t              state_q, state_d;
  logic [addr_bus-1:0] counter_q, last_q;
  logic                cnt_clr, cnt_inc, ser_load;
  logic                ser_valid, ser_last;
  logic [7:0]          ser_byte;

  word_serializer #(.data_size(data_size)) u_ser (
    .Clk       (Clk),
    .Reset     (Reset),
    .load      (ser_load),
    .word      (bus.Mem_Data),
    .active    (state_q == ST_SEND),
    .ready     (bus.Tx_Ready),
    .valid     (ser_valid),
    .byte_data (ser_byte),
    .last_byte (ser_last)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      counter_q <= '0;
      last_q    <= '0;
    end else if (cnt_clr) begin
      counter_q <= '0;
      last_q    <= Last_Addr;
    end else if (cnt_inc) begin
      counter_q <= counter_q + addr_bus'(1);
    end
  end

  // The end test is done on the current address, so the top address finishes
  // the dump instead of wrapping back to 0.
  always_comb begin
    state_d  = state_q;
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    ser_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          cnt_clr = 1'b1;
`ifdef MEM_DUMP_HEADER_EN
          state_d = ST_HEADER;
`else
          state_d = ST_READ;
`endif
        end
      end
`ifdef MEM_DUMP_HEADER_EN
      ST_HEADER: if (bus.Tx_Ready) state_d = ST_READ;
`endif
      ST_READ: begin
        ser_load = 1'b1;
        state_d  = ST_SEND;
      end
      ST_SEND: begin
        if (ser_valid && bus.Tx_Ready && ser_last) begin
          if (counter_q == last_q) begin
            state_d = ST_FINISH;
          end else begin
            cnt_inc = 1'b1;
            state_d = ST_READ;
          end
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.Tx_Data  = '0;
    bus.Tx_Valid = 1'b0;
    if (state_q == ST_SEND) begin
      bus.Tx_Valid = ser_valid;
      bus.Tx_Data  = ser_byte;
    end
`ifdef MEM_DUMP_HEADER_EN
    if (state_q == ST_HEADER) begin
      bus.Tx_Valid = 1'b1;
      bus.Tx_Data  = HEADER_BYTE;
    end
`endif
  end

  assign bus.Mem_Rd   = (state_q == ST_READ);
  assign bus.Mem_Addr = (state_q == ST_READ) ? counter_q : '0;
  assign Busy         = (state_q != ST_IDLE);
  assign Done         = (state_q == ST_FINISH);
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_mem_dump_unit.sv
// Directed bench for mem_dump_unit: table of dump cases plus stall, restart,
// reset and top-address sequences. Works with or without MEM_DUMP_HEADER_EN.
module tb_mem_dump_unit;
  import mem_dump_pkg::*;

  localparam int AW = 11;
  localparam int DW = 16;
`ifdef MEM_DUMP_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif
  localparam int EXP_LAT = (HDR == 1) ? 1 : 2;

  typedef struct {
    logic [AW-1:0] last_addr;
    logic [DW-1:0] w0, w1, w2;
    int            n_bytes;
    logic [47:0]   exp_bytes;
  } vec_t;

  logic          Clk, Reset, Start;
  logic [AW-1:0] Last_Addr;
  logic          Busy, Done;
  state_t        dbg_state;

  mem_dump_if #(.addr_bus(AW), .data_size(DW)) bus ();

  mem_dump_unit #(.addr_bus(AW), .data_size(DW)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Start     (Start),
    .Last_Addr (Last_Addr),
    .bus       (bus.master),
    .Busy      (Busy),
    .Done      (Done),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // ---------------- memory model ----------------
  logic [DW-1:0] mem [0:(1<<AW)-1];
  assign bus.Mem_Data = mem[bus.Mem_Addr];

  // ---------------- scoreboard ----------------
  logic [7:0]    exp_q[$];
  logic [7:0]    got_q[$];
  logic [AW-1:0] rd_q[$];
  int            done_cnt, addr_viol, done_base;
  int            errors, checks;

  always @(negedge Clk) begin
    if (!Reset) begin
      if (bus.Tx_Valid && bus.Tx_Ready) got_q.push_back(bus.Tx_Data);
      if (Done) done_cnt++;
      if (bus.Mem_Rd) rd_q.push_back(bus.Mem_Addr);
      if (!bus.Mem_Rd && bus.Mem_Addr != '0) addr_viol++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_neg();
    @(negedge Clk);
    #1;
  endtask

  task automatic clear_sb();
    exp_q.delete();
    got_q.delete();
    rd_q.delete();
    if (HDR == 1) exp_q.push_back(HEADER_BYTE);
  endtask

  task automatic start_dump(input logic [AW-1:0] la);
    int lat;
    done_base = done_cnt;
    @(posedge Clk); #1;
    Start = 1'b1;
    Last_Addr = la;
    @(posedge Clk); #1;
    Start = 1'b0;
    Last_Addr = ~la;
    lat = 0;
    while (lat < 8) begin
      wait_neg();
      lat++;
      if (bus.Tx_Valid) break;
    end
    check("start_latency", lat, EXP_LAT);
    check("busy_running", {31'b0, Busy}, 1);
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done_cnt == done_base && n < budget) begin
      wait_neg();
      n++;
    end
    check("done_seen", {31'b0, done_cnt != done_base}, 1);
    repeat (3) wait_neg();
    check("done_pulses", done_cnt - done_base, 1);
    check("busy_after", {31'b0, Busy}, 0);
    check("state_idle", 32'(dbg_state), 32'(ST_IDLE));
  endtask

  task automatic compare_bytes(input string name);
    int bad;
    check({name, "_count"}, got_q.size(), exp_q.size());
    if (exp_q.size() <= 8) begin
      for (int i = 0; i < exp_q.size(); i++)
        check({name, "_byte"}, (i < got_q.size()) ? 32'(got_q[i]) : 32'hFFFF, 32'(exp_q[i]));
    end else begin
      bad = 0;
      for (int i = 0; i < exp_q.size(); i++)
        if (i >= got_q.size() || got_q[i] !== exp_q[i]) bad++;
      check({name, "_bad_bytes"}, bad, 0);
    end
  endtask

  // ---------------- test ----------------
  vec_t vecs[4];

  initial begin
    errors = 0; checks = 0; done_cnt = 0; addr_viol = 0; done_base = 0;
    Reset = 1'b1; Start = 1'b0; Last_Addr = '0; bus.Tx_Ready = 1'b1;
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;

    vecs[0] = '{11'd2, 16'h1234, 16'hABCD, 16'h0001, 6, 48'h1234ABCD0001};
    vecs[1] = '{11'd0, 16'h5A5A, 16'h0000, 16'h0000, 2, 48'h00000000_5A5A};
    vecs[2] = '{11'd1, 16'hFFFF, 16'h8001, 16'h0000, 4, 48'h0000FFFF8001};
    vecs[3] = '{11'd2, 16'h0000, 16'h00FF, 16'hFF00, 6, 48'h000000FFFF00};

    // Reset state
    #12;
    check("rst_mem_rd",   {31'b0, bus.Mem_Rd}, 0);
    check("rst_mem_addr", 32'(bus.Mem_Addr), 0);
    check("rst_tx_data",  32'(bus.Tx_Data), 0);
    check("rst_tx_valid", {31'b0, bus.Tx_Valid}, 0);
    check("rst_busy",     {31'b0, Busy}, 0);
    check("rst_done",     {31'b0, Done}, 0);
    @(negedge Clk); Reset = 1'b0;
    repeat (2) wait_neg();

    // Table-driven dumps, Tx_Ready held high
    for (int v = 0; v < 4; v++) begin
      clear_sb();
      mem[0] = vecs[v].w0; mem[1] = vecs[v].w1; mem[2] = vecs[v].w2;
      for (int b = vecs[v].n_bytes - 1; b >= 0; b--) exp_q.push_back(vecs[v].exp_bytes[b*8 +: 8]);
      start_dump(vecs[v].last_addr);
      wait_done(200);
      compare_bytes("table");
    end

    mem[0] = 16'h1234; mem[1] = 16'hABCD; mem[2] = 16'h0001;

    // Stall: Tx_Ready low while the first byte is offered
    clear_sb();
    exp_q.push_back(8'h12); exp_q.push_back(8'h34); exp_q.push_back(8'hAB);
    exp_q.push_back(8'hCD); exp_q.push_back(8'h00); exp_q.push_back(8'h01);
    bus.Tx_Ready = 1'b0;
    start_dump(11'd2);
    for (int c = 0; c < 5; c++) begin
      wait_neg();
      check("stall_data",  32'(bus.Tx_Data), (HDR == 1) ? 32'hA5 : 32'h12);
      check("stall_valid", {31'b0, bus.Tx_Valid}, 1);
    end
    check("stall_no_xfer", got_q.size(), 0);
    @(posedge Clk); #1;
    bus.Tx_Ready = 1'b1;
    wait_done(200);
    compare_bytes("stall");

    // Start pulsed again mid-dump must not restart
    clear_sb();
    start_dump(11'd2);
    repeat (2) wait_neg();
    @(posedge Clk); #1; Start = 1'b1;
    @(posedge Clk); #1; Start = 1'b0;
    wait_done(200);
    check("restart_count", got_q.size(), 6 + HDR);

    // Reset while sending word 1
    clear_sb();
    start_dump(11'd2);
    for (int n = 0; n < 50; n++) begin
      if (got_q.size() >= 3 + HDR && bus.Tx_Valid) break;
      wait_neg();
    end
    check("mid_state_send", 32'(dbg_state), 32'(ST_SEND));
    Reset = 1'b1;
    #1;
    check("mid_rst_mem_rd",   {31'b0, bus.Mem_Rd}, 0);
    check("mid_rst_mem_addr", 32'(bus.Mem_Addr), 0);
    check("mid_rst_tx_data",  32'(bus.Tx_Data), 0);
    check("mid_rst_tx_valid", {31'b0, bus.Tx_Valid}, 0);
    check("mid_rst_busy",     {31'b0, Busy}, 0);
    check("mid_rst_done",     {31'b0, Done}, 0);
    wait_neg();
    Reset = 1'b0;
    wait_neg();
    clear_sb();
    exp_q.push_back(8'h12); exp_q.push_back(8'h34); exp_q.push_back(8'hAB);
    exp_q.push_back(8'hCD); exp_q.push_back(8'h00); exp_q.push_back(8'h01);
    start_dump(11'd2);
    wait_done(200);
    compare_bytes("after_rst");
    check("after_rst_first_addr", (rd_q.size() > 0) ? 32'(rd_q[0]) : 32'hFFFF, 0);

    // Full address range, top address ends the dump
    clear_sb();
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i] = 16'(i * 16'h0107) ^ 16'h5A3C;
      if (i == (1 << AW) - 1) mem[i] = 16'hBEEF;
      exp_q.push_back(mem[i][15:8]);
      exp_q.push_back(mem[i][7:0]);
    end
    start_dump(11'h7FF);
    wait_done(8000);
    compare_bytes("top");
    check("top_last_hi", (got_q.size() >= 2) ? 32'(got_q[got_q.size()-2]) : 32'hFFFF, 32'hBE);
    check("top_last_lo", (got_q.size() >= 1) ? 32'(got_q[got_q.size()-1]) : 32'hFFFF, 32'hEF);
    check("top_reads", rd_q.size(), 1 << AW);
    check("top_final_read", (rd_q.size() > 0) ? 32'(rd_q[rd_q.size()-1]) : 32'hFFFF, 32'h7FF);

    check("mem_addr_idle_zero", addr_viol, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_dump_unit.md
MEM_DUMP_UNIT -- requirements
Module: mem_dump_unit

Interface
REQ-001 SHALL have parameter addr_bus, default 11, data memory address width.
REQ-002 SHALL have parameter data_size, default 16, data memory word width; must be a multiple of 8.
REQ-003 SHALL have port Clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port Reset, input, 1, asynchronous, active-high reset.
REQ-005 SHALL have port Start, input, 1, requests a dump; sampled only in IDLE.
REQ-006 SHALL have port Last_Addr, input, addr_bus, inclusive final address; captured when Start is accepted.
REQ-007 SHALL have port Mem_Rd, output, 1, read strobe to the data memory.
REQ-008 SHALL have port Mem_Addr, output, addr_bus, data memory address.
REQ-009 SHALL have port Mem_Data, input, data_size, combinational read data from the data memory.
REQ-010 SHALL have port Tx_Data, output, 8, byte offered to the UART transmitter.
REQ-011 SHALL have port Tx_Valid, output, 1, Tx_Data is valid.
REQ-012 SHALL have port Tx_Ready, input, 1, transmitter accepts the byte this cycle.
REQ-013 SHALL have port Busy, output, 1, high in every state except IDLE.
REQ-014 SHALL have port Done, output, 1, one-cycle pulse when the dump completes.

Function
REQ-015 SHALL implement states IDLE, READ, SEND and FINISH, plus HEADER when the feature in REQ-028 is enabled.
REQ-016 SHALL move IDLE->READ when Start=1, clear the address counter to 0 and capture Last_Addr.
REQ-017 SHALL drive Mem_Rd=1 and Mem_Addr=counter only in READ; Mem_Rd=0 and Mem_Addr=0 in all other states.
REQ-018 SHALL latch Mem_Data into the word register at the end of the single READ cycle, then enter SEND.
REQ-019 SHALL in SEND hold Tx_Valid=1 and offer data_size/8 bytes, most significant byte first.
REQ-020 SHALL complete a byte transfer only on a rising edge with Tx_Valid=1 and Tx_Ready=1; Tx_Data and Tx_Valid stay stable until then.
REQ-021 SHALL after the last byte of a word go to FINISH when counter==captured Last_Addr, else increment the counter and go to READ.
REQ-022 SHALL compare before incrementing, so Last_Addr=2**addr_bus-1 ends the dump without wrapping to 0.
REQ-023 SHALL assert Done=1 for exactly the FINISH cycle, then return to IDLE.
REQ-024 SHALL ignore Start while Busy=1; changes to Last_Addr after capture have no effect.
REQ-025 SHALL give latency of 2 cycles from Start accepted to first Tx_Valid=1 when the feature in REQ-028 is disabled.

Reset
REQ-026 SHALL on Reset=1, asynchronously and mid-operation included, enter IDLE and clear the counter, word register and byte index.
REQ-027 SHALL hold all outputs at 0 during reset: Mem_Rd, Mem_Addr, Tx_Data, Tx_Valid, Busy, Done.

Configuration
REQ-028 SHALL compile in a header under macro MEM_DUMP_HEADER_EN: Start goes to HEADER, which offers byte 0xA5 under REQ-020 rules and then enters READ. Start-to-first-Tx_Valid latency is 1 cycle.
REQ-029 SHALL without MEM_DUMP_HEADER_EN omit the HEADER state, so the first byte is the MSB of word 0.

Structure
REQ-030 SHALL place the state encoding and the HEADER_BYTE constant (8'hA5) in shared package mem_dump_pkg.
REQ-031 SHALL put word-to-byte splitting in a sub-module word_serializer, with load, byte index, valid/ready and last-byte flag.

Verification
REQ-032 SHALL cover: Last_Addr=2, mem[0..2]=16'h1234,16'hABCD,16'h0001, Tx_Ready=1 -> bytes 12,34,AB,CD,00,01, then one Done pulse.
REQ-033 SHALL cover: Tx_Ready=0 for 5 cycles while Tx_Valid=1 -> Tx_Data held at 8'h12; exactly one transfer when Tx_Ready rises.
REQ-034 SHALL cover: Start pulsed again mid-dump -> no restart; byte count stays 6.
REQ-035 SHALL cover: Reset asserted during SEND of word 1 -> all outputs 0 immediately; a new Start dumps again from address 0.
REQ-036 SHALL cover: Last_Addr=11'h7FF, mem[7FF]=16'hBEEF -> final bytes BE,EF, Done, no Mem_Addr=0 read after 7FF.
REQ-037 SHALL cover: with MEM_DUMP_HEADER_EN and Last_Addr=0, mem[0]=16'h5A5A -> bytes A5,5A,5A.
